// File: rtl/m_seg7_scanner.sv
// Six-digit multiplexed seven-segment driver for a common-anode display.
// Snapshots min/sec/msec once per frame and scans digits with a blanking gap.
module m_seg7_scanner #(
    parameter int P_SCAN_DIV     = 8192,
    parameter int P_BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [7:0] msec,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] dig,
    output logic       frame_start
);

    localparam int CW = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(P_SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(P_BLANK_CYCLES - 1);

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic [2:0]    idx;
    logic [7:0]    min_q;
    logic [7:0]    sec_q;
    logic [7:0]    msec_q;
    logic          snap_edge;
    logic [3:0]    cur_nib;
    logic [6:0]    glyph;
    logic          lz_hide;

    assign snap_edge = (slot_cnt == '0) && (idx == 3'd0);

    always_comb begin
        cur_nib = 4'h0;
        case (idx)
            3'd0:    cur_nib = msec_q[3:0];
            3'd1:    cur_nib = msec_q[7:4];
            3'd2:    cur_nib = sec_q[3:0];
            3'd3:    cur_nib = sec_q[7:4];
            3'd4:    cur_nib = min_q[3:0];
            3'd5:    cur_nib = min_q[7:4];
            default: cur_nib = 4'h0;
        endcase
    end

    // Active-high {g..a}; anything that is not a BCD digit shows a dash.
    always_comb begin
        glyph = 7'b1000000;
        case (cur_nib)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b1000000;
        endcase
    end

    // lz_blank is deliberately taken live rather than from the snapshot.
    assign lz_hide = lz_blank && (idx == 3'd5) && (min_q[7:4] == 4'h0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot_cnt    <= '0;
            idx         <= 3'd0;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            msec_q      <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_edge;
            if (snap_edge) begin
                min_q  <= min;
                sec_q  <= sec;
                msec_q <= msec;
            end
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // State mirrors the phase of the current slot_cnt; outputs therefore
    // trail the counter by one register stage.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_BLANK;
            dig   <= 6'h3F;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            case (state)
                S_BLANK: begin
                    dig <= 6'h3F;
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                    if (slot_cnt == BLANK_LAST) begin
                        state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    dig <= ~(6'd1 << idx);
                    seg <= lz_hide ? 7'h7F : ~glyph;
                    dp  <= !((idx == 3'd2) || (idx == 3'd4));
                    if (slot_cnt == SLOT_LAST) begin
                        state <= S_BLANK;
                    end
                end
                default: begin
                    state <= S_BLANK;
                    dig   <= 6'h3F;
                    seg   <= 7'h7F;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_seg7_scanner.sv
// Bench for m_seg7_scanner: cycle-accurate reference built from frame
// position arithmetic, plus directed glyph, timing and reset checks.
module tb_m_seg7_scanner;

    localparam int D = 16;
    localparam int B = 2;
    localparam int F = 6 * D;
    localparam logic [15:0] DARK = {3'b001, 6'h3F, 7'h7F};

    logic       clk;
    logic       n_reset;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] msec;
    logic       lz_blank;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       frame_start;

    int n_vec = 0;
    int n_err = 0;
    int t_cnt = 0;
    int t_last = -1;
    logic [23:0] snap = 24'h0;
    logic [15:0] exp_v;

    logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                      7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                      7'h40, 7'h40, 7'h40, 7'h40};

    m_seg7_scanner #(
        .P_SCAN_DIV(D),
        .P_BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .min(min),
        .sec(sec),
        .msec(msec),
        .lz_blank(lz_blank),
        .seg(seg),
        .dp(dp),
        .dig(dig),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Output expected in the cycle after the t-th edge since reset release.
    function automatic logic [15:0] model_out(int t, logic [23:0] sn, logic lz);
        int p;
        int i;
        int s;
        logic [3:0] nib;
        logic [6:0] sg;
        logic [5:0] dg;
        logic d;
        logic fs;
        p  = t % F;
        i  = p / D;
        s  = p % D;
        fs = (p == 0);
        dg = 6'h3F;
        sg = 7'h7F;
        d  = 1'b1;
        if (s >= B) begin
            dg  = 6'h3F & ~(6'd1 << i);
            nib = sn[4*i +: 4];
            sg  = ~glyph_tab[nib];
            if (i == 5 && lz && nib == 4'h0) sg = 7'h7F;
            d = !(i == 2 || i == 4);
        end
        return {1'b0, fs, d, dg, sg};
    endfunction

    function automatic logic [15:0] observed();
        return {1'b0, frame_start, dp, dig, seg};
    endfunction

    task automatic step();
        @(posedge clk);
        if (n_reset) begin
            if (t_cnt % F == 0) snap = {min, sec, msec};
            exp_v  = model_out(t_cnt, snap, lz_blank);
            t_last = t_cnt;
            t_cnt++;
        end else begin
            exp_v  = DARK;
            t_last = -1;
            t_cnt  = 0;
        end
        #1;
        check_val("out", observed(), exp_v);
        check_val("onehot", 16'($countones(~dig) <= 1), 16'd1);
        @(negedge clk);
    endtask

    task automatic run_to(input int p);
        bit found;
        found = 1'b0;
        for (int k = 0; k <= F && !found; k++) begin
            step();
            if (t_last >= 0 && (t_last % F) == p) found = 1'b1;
        end
        check_val("run_to_reached", 16'(found), 16'd1);
    endtask

    initial begin
        int blanks;
        int pulses;
        n_reset  = 1'b1;
        min      = 8'h12;
        sec      = 8'h34;
        msec     = 8'h56;
        lz_blank = 1'b0;
        #2 n_reset = 1'b0;
        #1 check_val("rst_init", observed(), DARK);
        for (int k = 0; k < 3; k++) step();
        n_reset = 1'b1;

        // Glyphs and decimal points
        run_to(2);
        check_val("idx0_glyph6", {3'b0, dig, seg}, {3'b0, 6'h3E, 7'h02});
        run_to(D + 2);
        check_val("dp_idx1_off", 16'(dp), 16'd1);
        run_to(2 * D + 2);
        check_val("dp_idx2_on", 16'(dp), 16'd0);
        run_to(4 * D + 5);
        check_val("dp_idx4_on", 16'(dp), 16'd0);
        run_to(5 * D + 2);
        check_val("idx5_glyph1", {3'b0, dig, seg}, {3'b0, 6'h1F, 7'h79});

        // One full frame: blank cycles and frame_start pulses
        run_to(F - 1);
        blanks = 0;
        pulses = 0;
        for (int k = 0; k < F; k++) begin
            step();
            if (dig == 6'h3F) blanks++;
            if (frame_start) pulses++;
        end
        check_val("blank_cnt", 16'(blanks), 16'(6 * B));
        check_val("fs_cnt", 16'(pulses), 16'd1);

        // Snapshot coherency
        run_to(3 * D + 2);
        msec = 8'h57;
        run_to(4 * D);
        run_to(2);
        check_val("coh_glyph7", 16'(seg), 16'h78);

        // Leading zero, live lz_blank and invalid BCD
        min      = 8'h05;
        lz_blank = 1'b1;
        run_to(0);
        run_to(5 * D + 2);
        check_val("lz_on", 16'(seg), 16'h7F);
        check_val("lz_dig", 16'(dig), 16'h1F);
        lz_blank = 1'b0;
        run_to(5 * D + 2);
        check_val("lz_off", 16'(seg), 16'h40);
        sec = 8'hA0;
        run_to(0);
        run_to(3 * D + 2);
        check_val("bad_bcd", 16'(seg), 16'h3F);

        // Reset pulse in the middle of idx4
        run_to(4 * D + 6);
        n_reset = 1'b0;
        #1 check_val("async_rst", observed(), DARK);
        for (int k = 0; k < 3; k++) step();
        n_reset = 1'b1;
        step();
        check_val("restart_fs", 16'(frame_start), 16'd1);
        run_to(2);
        check_val("restart_idx0", 16'(dig), 16'h3E);

        // Random inputs, including changes right before snapshot edges
        for (int k = 0; k < 12 * F; k++) begin
            if ($urandom_range(0, 19) == 0) min = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) min[7:4] = 4'h0;
            if ($urandom_range(0, 19) == 0) sec = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) msec = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) lz_blank = ~lz_blank;
            if (t_last >= 0 && (t_last % F) == F - 1) msec = 8'($urandom_range(0, 255));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_seg7_scanner.md
# m_seg7_scanner

Multiplexed 6-digit seven-segment display driver that consumes the stopwatch's BCD `min`/`sec`/`msec` outputs and drives the board's common-anode display. Takes a coherent snapshot of all six digits at the start of each scan frame, then time-multiplexes the digits with an inter-digit blanking interval to suppress ghosting. Sits between `m_stop_watch` and the top-level display pins.

## Interface
- `P_SCAN_DIV`, default 8192: clock cycles per digit slot. At 50 MHz this is 163.84 µs per slot, about 1.02 kHz frame rate. Legal range 2..2^16.
- `P_BLANK_CYCLES`, default 64: cycles at the start of each slot with all digits off. Legal range 1..`P_SCAN_DIV`-1.
- `clk`  in  1  system clock, single clock domain.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `min`  in  8  BCD minutes, {tens, ones}.
- `sec`  in  8  BCD seconds, {tens, ones}.
- `msec`  in  8  BCD centiseconds, {tens, ones}.
- `lz_blank`  in  1  when 1, blank the minutes-tens digit if it is 0.
- `seg`  out  7  segments, bit0=a … bit6=g, active-low.
- `dp`  out  1  decimal point, active-low.
- `dig`  out  6  digit enables, one-hot, active-low. bit0 is the rightmost digit.
- `frame_start`  out  1  one-cycle pulse, high when a new snapshot is in use.

## Operation
- Digit map:
  - idx0 = `msec[3:0]`, idx1 = `msec[7:4]`
  - idx2 = `sec[3:0]`, idx3 = `sec[7:4]`
  - idx4 = `min[3:0]`, idx5 = `min[7:4]`
- Counters and state:
  - `slot_cnt` runs 0..`P_SCAN_DIV`-1.
  - On wrap, `idx` advances 0→1→…→5→0.
  - FSM per slot: S_BLANK while `slot_cnt` < `P_BLANK_CYCLES`, otherwise S_DRIVE.
  - S_BLANK → S_DRIVE at `slot_cnt` = `P_BLANK_CYCLES`.
  - S_DRIVE → S_BLANK at slot wrap.
- Snapshot: on the clock edge where `slot_cnt`=0 and `idx`=0, all 24 input bits are latched into shadow registers. The display uses only the shadow registers. Input changes mid-frame appear from the next frame only.
- Decode, per nibble:
  - 0–9 use the standard glyphs, active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - 0xA–0xF display as "-" (g only).
  - `seg` outputs the inverted value.
- `dp` is driven (0) only while idx2 or idx4 is driven, marking min.sec.csec. It is 1 otherwise.
- Leading zero: when `lz_blank`=1 and shadow `min[7:4]`=0, the idx5 slot drives `seg`=7'h7F. `dig` still asserts bit5, so timing is unchanged. `lz_blank` is sampled live, not snapshotted.
- S_BLANK outputs: `dig`=6'h3F, `seg`=7'h7F, `dp`=1.
- S_DRIVE outputs: `dig`=~(1<<`idx`), with decoded `seg` and `dp`.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (asynchronous, immediate): `slot_cnt`=0, `idx`=0, shadows=0, `dig`=6'h3F, `seg`=7'h7F, `dp`=1, `frame_start`=0.
- First rising edge after `n_reset` deasserts = edge E0. The snapshot is taken at E0.
- `frame_start` is high in the cycle after E0 for exactly one cycle. It repeats every 6·`P_SCAN_DIV` cycles.
- Each slot shows `P_BLANK_CYCLES` output cycles blank, then `P_SCAN_DIV`-`P_BLANK_CYCLES` cycles driven. The output lags `slot_cnt` by one register stage.
- Slot boundaries: `dig` is never active for two digits at once. The last driven cycle of slot n is always followed by at least `P_BLANK_CYCLES` blank cycles.
- Reset asserted mid-slot: outputs go dark asynchronously. The scan restarts at idx0 with a fresh snapshot on the first edge after release.
- A snapshot edge coinciding with an input change captures the pre-edge input value.

## Test plan
Run with `P_SCAN_DIV`=16 and `P_BLANK_CYCLES`=2. Frame = 96 cycles.
- Reset: hold `n_reset`=0 mid-scan → `dig`=6'h3F, `seg`=7'h7F, `dp`=1, `frame_start`=0 immediately, without waiting for a clock edge.
- Glyphs: `min`=8'h12, `sec`=8'h34, `msec`=8'h56 →
  - idx0 driven: `dig`=6'b111110, `seg`=7'h02 ("6").
  - idx5 driven: `dig`=6'b011111, `seg`=7'h79 ("1").
  - `dp`=0 only during the idx2 and idx4 drive windows.
- Blank/period: count cycles → each slot has 2 cycles with `dig`=6'h3F and 14 cycles one-hot. `frame_start` pulses every 96 cycles. Never more than one `dig` bit low.
- Snapshot coherency: change `msec` 8'h56→8'h57 during the idx3 slot → idx0 and idx1 keep the old value for the rest of the frame. The next frame's idx0 shows `seg`=7'h78 ("7").
- Leading zero and invalid BCD: `min`=8'h05 →
  - `lz_blank`=1: idx5 `seg`=7'h7F.
  - `lz_blank`=0: idx5 `seg`=7'h40.
  - `sec`=8'hA0: idx3 `seg`=7'h3F ("-").
- Reset mid-frame: pulse `n_reset` low for 3 cycles during idx4 → after release, idx0 is driven first and `frame_start` fires one cycle after the first edge.
